// File: rtl/life_step_scheduler.sv
// Game-of-Life generation sequencer: timer/step trigger, vblank-aligned engine starts.
// Define LIFE_SCHED_WATCHDOG_EN to add the per-phase watchdog and sticky wdog_err.
module life_step_scheduler #(
  parameter int UPDATE_INTERVAL = 2400000,
  parameter int GEN_W           = 16,
  parameter int WDOG_CYCLES     = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             randomize,
  input  logic             vblank,
  output logic             init_start,
  input  logic             init_done,
  output logic             upd_start,
  input  logic             upd_done,
  output logic             copy_start,
  input  logic             copy_done,
  output logic             busy,
  output logic [2:0]       phase,
  output logic [GEN_W-1:0] generation,
  output logic             wdog_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_UPDATE = 3'd2;
  localparam logic [2:0] S_COPY   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  localparam int TW =
    (UPDATE_INTERVAL > 1) ? $clog2(UPDATE_INTERVAL) : 1;
  localparam logic [TW-1:0] TMAX = TW'(UPDATE_INTERVAL - 1);

  logic [TW-1:0]    timer, timer_n;
  logic             rnd_q, rnd_n;
  logic             boot;
  logic [2:0]       phase_n;
  logic [GEN_W-1:0] gen_n;
  logic             init_n, upd_n, copy_n;

`ifdef LIFE_SCHED_WATCHDOG_EN
  localparam int WW =
    (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WMAX = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wcnt, wcnt_n;
  logic          timeout;
`endif

  always_comb begin
    phase_n = phase;
    gen_n   = generation;
    timer_n = timer;
    rnd_n   = rnd_q;
    init_n  = 1'b0;
    upd_n   = 1'b0;
    copy_n  = 1'b0;
    case (phase)
      S_IDLE: begin
        if (run) begin
          if (timer == TMAX) begin
            timer_n = '0;
            rnd_n   = randomize;
            phase_n = S_WAIT;
          end else begin
            timer_n = timer + 1'b1;
          end
        end else begin
          timer_n = '0;
          if (step) begin
            rnd_n   = randomize;
            phase_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (vblank) begin
          if (rnd_q) begin
            phase_n = S_INIT;
            init_n  = 1'b1;
          end else begin
            phase_n = S_UPDATE;
            upd_n   = 1'b1;
          end
        end
      end
      // The boot cycle issues the start; done is only honoured after it.
      S_INIT: begin
        if (boot) begin
          init_n = 1'b1;
        end else if (init_done) begin
          phase_n = S_IDLE;
          gen_n   = '0;
        end
      end
      S_UPDATE: begin
        if (upd_done) begin
          phase_n = S_COPY;
          copy_n  = 1'b1;
        end
      end
      S_COPY: begin
        if (copy_done) begin
          phase_n = S_IDLE;
          gen_n   = generation + 1'b1;
        end
      end
      default: phase_n = S_IDLE;
    endcase
`ifdef LIFE_SCHED_WATCHDOG_EN
    timeout = busy && !boot && (phase_n == phase) && (wcnt == WMAX);
    if (timeout) begin
      phase_n = S_IDLE;
    end
    if (init_n || upd_n || copy_n) begin
      wcnt_n = '0;
    end else if (busy && !timeout) begin
      wcnt_n = wcnt + 1'b1;
    end else begin
      wcnt_n = wcnt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= S_INIT;
      generation <= '0;
      timer      <= '0;
      rnd_q      <= 1'b0;
      boot       <= 1'b1;
      init_start <= 1'b0;
      upd_start  <= 1'b0;
      copy_start <= 1'b0;
      busy       <= 1'b1;
    end else begin
      phase      <= phase_n;
      generation <= gen_n;
      timer      <= timer_n;
      rnd_q      <= rnd_n;
      boot       <= 1'b0;
      init_start <= init_n;
      upd_start  <= upd_n;
      copy_start <= copy_n;
      busy       <= (phase_n == S_INIT) || (phase_n == S_UPDATE) ||
                    (phase_n == S_COPY);
    end
  end

`ifdef LIFE_SCHED_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt     <= '0;
      wdog_err <= 1'b0;
    end else begin
      wcnt     <= wcnt_n;
      wdog_err <= wdog_err | timeout;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_err    = 1'b0;
`endif

endmodule

// File: tb/tb_life_step_scheduler.sv
// Directed bench for life_step_scheduler with a generation-count scoreboard.
// Engines are modelled as fixed-latency responders plus injectable stray done pulses.
module tb_life_step_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic step = 1'b0;
  logic randomize = 1'b0;
  logic vblank = 1'b0;
  logic init_done_e = 1'b0, upd_done_e = 1'b0, copy_done_e = 1'b0;
  logic init_done_s = 1'b0, upd_done_s = 1'b0, copy_done_s = 1'b0;
  logic init_start, upd_start, copy_start, busy, wdog_err;
  logic [2:0] phase;
  logic [3:0] generation;

  int checks = 0;
  int errors = 0;
  bit eng_en = 1'b1;
  logic [3:0] model_gen = 4'd0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  life_step_scheduler #(
    .UPDATE_INTERVAL(8),
    .GEN_W(4),
    .WDOG_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .step(step),
    .randomize(randomize),
    .vblank(vblank),
    .init_start(init_start),
    .init_done(init_done_e | init_done_s),
    .upd_start(upd_start),
    .upd_done(upd_done_e | upd_done_s),
    .copy_start(copy_start),
    .copy_done(copy_done_e | copy_done_s),
    .busy(busy),
    .phase(phase),
    .generation(generation),
    .wdog_err(wdog_err)
  );

  // Fixed-latency engines: done pulses 3 cycles after the start is seen.
  initial begin
    int cnt;
    int which;
    cnt = 0;
    which = 0;
    forever begin
      @(posedge clk);
      #1;
      init_done_e = 1'b0;
      upd_done_e  = 1'b0;
      copy_done_e = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && eng_en) begin
          case (which)
            1: init_done_e = 1'b1;
            2: upd_done_e  = 1'b1;
            3: copy_done_e = 1'b1;
            default: ;
          endcase
        end
      end
      if (eng_en) begin
        if (init_start) begin which = 1; cnt = 3; end
        if (upd_start)  begin which = 2; cnt = 3; end
        if (copy_start) begin which = 3; cnt = 3; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input logic [2:0] tgt, input string tag);
    int n;
    n = 0;
    while (phase !== tgt && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(phase), 32'(tgt));
  endtask

  task automatic finish_gen(input string tag);
    logic [3:0] e;
    wait_phase(3'd0, tag);
    e = exp_q.pop_front();
    chk(tag, 32'(generation), 32'(e));
  endtask

  task automatic step_gen();
    model_gen = model_gen + 4'd1;
    exp_q.push_back(model_gen);
    step = 1'b1;
    tick();
    step = 1'b0;
    finish_gen("step_gen");
  endtask

  initial begin
    int n;
    tick();
    chk("rst_phase", 32'(phase), 1);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_gen", 32'(generation), 0);
    chk("rst_init_start", 32'(init_start), 0);
    chk("rst_upd_start", 32'(upd_start), 0);
    chk("rst_wdog", 32'(wdog_err), 0);
    reset = 1'b0;
    tick();
    chk("boot_init_start", 32'(init_start), 1);
    chk("boot_phase", 32'(phase), 1);
    exp_q.push_back(4'd0);
    finish_gen("boot_done");
    chk("boot_busy", 32'(busy), 0);

    vblank = 1'b1;
    run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      model_gen = model_gen + 4'd1;
      exp_q.push_back(model_gen);
      n = 0;
      while (!upd_start && n < 30) begin
        tick();
        n++;
      end
      chk("interval", 32'(n), 9);
      n = 0;
      while (!copy_start && n < 30) begin
        tick();
        n++;
      end
      chk("copy_phase", 32'(phase), 3);
      finish_gen("run_gen");
    end
    run = 1'b0;

    vblank = 1'b0;
    model_gen = model_gen + 4'd1;
    exp_q.push_back(model_gen);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("wait_enter", 32'(phase), 4);
    repeat (3) tick();
    chk("wait_hold", 32'(phase), 4);
    chk("wait_no_start", 32'(upd_start), 0);
    vblank = 1'b1;
    tick();
    chk("vblank_upd", 32'(phase), 2);
    chk("vblank_upd_start", 32'(upd_start), 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    finish_gen("step_gen_once");
    repeat (12) tick();
    chk("dropped_step_phase", 32'(phase), 0);
    chk("dropped_step_gen", 32'(generation), 32'(model_gen));

    step_gen();
    step_gen();
    chk("gen_five", 32'(generation), 5);
    randomize = 1'b1;
    vblank = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    randomize = 1'b0;
    chk("rnd_wait", 32'(phase), 4);
    tick();
    vblank = 1'b1;
    tick();
    chk("rnd_init", 32'(phase), 1);
    chk("rnd_init_start", 32'(init_start), 1);
    model_gen = 4'd0;
    exp_q.push_back(4'd0);
    finish_gen("rnd_clear");

    copy_done_s = 1'b1;
    tick();
    copy_done_s = 1'b0;
    tick();
    chk("stray_idle_phase", 32'(phase), 0);
    chk("stray_idle_gen", 32'(generation), 0);
    eng_en = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("man_upd_start", 32'(upd_start), 1);
    upd_done_s = 1'b1;
    tick();
    upd_done_s = 1'b0;
    chk("early_done_copy", 32'(phase), 3);
    chk("early_done_cstart", 32'(copy_start), 1);
    upd_done_s = 1'b1;
    init_done_s = 1'b1;
    tick();
    upd_done_s = 1'b0;
    init_done_s = 1'b0;
    chk("stray_copy_phase", 32'(phase), 3);
    chk("stray_copy_gen", 32'(generation), 0);
    copy_done_s = 1'b1;
    tick();
    copy_done_s = 1'b0;
    model_gen = 4'd1;
    chk("man_copy_idle", 32'(phase), 0);
    chk("man_copy_gen", 32'(generation), 1);
    eng_en = 1'b1;
    tick();

    for (int k = 0; k < 14; k++) step_gen();
    chk("gen_max", 32'(generation), 32'hF);
    step_gen();
    chk("gen_wrap", 32'(generation), 0);

    eng_en = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("wd_upd_start", 32'(upd_start), 1);
    n = 0;
    while (!wdog_err && n < 40) begin
      tick();
      n++;
    end
`ifdef LIFE_SCHED_WATCHDOG_EN
    chk("wd_cycles", 32'(n), 16);
    chk("wd_phase", 32'(phase), 0);
    chk("wd_gen", 32'(generation), 32'(model_gen));
    upd_done_s = 1'b1;
    tick();
    upd_done_s = 1'b0;
    tick();
    chk("wd_stray_phase", 32'(phase), 0);
    chk("wd_sticky", 32'(wdog_err), 1);
    chk("wd_stray_gen", 32'(generation), 32'(model_gen));
`else
    chk("nowd_err", 32'(wdog_err), 0);
    chk("nowd_hold", 32'(phase), 2);
    chk("nowd_busy", 32'(busy), 1);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_phase", 32'(phase), 1);
    chk("midrst_gen", 32'(generation), 0);
    chk("midrst_busy", 32'(busy), 1);
    chk("midrst_wdog", 32'(wdog_err), 0);
    chk("midrst_upd", 32'(upd_start), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
